// File: rtl/idli_seq_m_if.sv
// Handshake bundle between the nibble-serial sequencer and its memory/decode/execute neighbours.
// The sequencer connects through the slave modport; whoever stimulates it uses master.
interface idli_seq_m_if;
  logic       i_seq_mem_rdy;
  logic [1:0] i_seq_ex_passes;
  logic       i_seq_ex_wait;
  logic       i_seq_redirect;
  logic [2:0] o_seq_state;
  logic [1:0] o_seq_ctr;
  logic       o_seq_last_cycle;
  logic       o_seq_pc_en;
  logic       o_seq_pc_ld;
  logic       o_seq_mem_req;
  logic       o_seq_ir_en;
  logic       o_seq_ex_en;

  modport master (
    output i_seq_mem_rdy, i_seq_ex_passes, i_seq_ex_wait, i_seq_redirect,
    input  o_seq_state, o_seq_ctr, o_seq_last_cycle, o_seq_pc_en,
           o_seq_pc_ld, o_seq_mem_req, o_seq_ir_en, o_seq_ex_en
  );

  modport slave (
    input  i_seq_mem_rdy, i_seq_ex_passes, i_seq_ex_wait, i_seq_redirect,
    output o_seq_state, o_seq_ctr, o_seq_last_cycle, o_seq_pc_en,
           o_seq_pc_ld, o_seq_mem_req, o_seq_ir_en, o_seq_ex_en
  );
endinterface

// File: rtl/idli_seq_m.sv
// Nibble-serial instruction sequencer: IDLE -> ADDR -> DATA -> EXEC (n passes) -> ADDR or JUMP.
// Every 16-bit pass is four nibble cycles counted by ctr; stalls freeze ctr and state.
module idli_seq_m (
  input  logic        i_seq_gck,
  input  logic        i_seq_rst_n,
  idli_seq_m_if.slave seq
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    EXEC = 3'd3,
    JUMP = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ctr_q, ctr_d;
  logic [1:0] pass_q, pass_d;
  logic       ex_first_q, ex_first_d;
  logic       adv;
  logic       active;
  logic       last;

  // Encodings 5..7 behave exactly like IDLE: always advance, never report a last nibble.
  always_comb begin
    adv    = 1'b1;
    active = 1'b0;
    case (state_q)
      ADDR: active = 1'b1;
      DATA: begin
        adv    = seq.i_seq_mem_rdy;
        active = 1'b1;
      end
      EXEC: begin
        adv    = !seq.i_seq_ex_wait;
        active = 1'b1;
      end
      JUMP: active = 1'b1;
      default: begin
        adv    = 1'b1;
        active = 1'b0;
      end
    endcase
  end

  assign last = (ctr_q == 2'd3) && adv && active;

  always_comb begin
    state_d    = state_q;
    ctr_d      = adv ? ctr_q + 2'd1 : ctr_q;
    pass_d     = pass_q;
    ex_first_d = ex_first_q;
    case (state_q)
      ADDR: if (last) state_d = DATA;
      DATA: begin
        if (last) begin
          state_d    = EXEC;
          ex_first_d = 1'b1;
        end
      end
      EXEC: begin
        // Pass count is sampled once, on the first nibble that actually executes.
        if (adv && ex_first_q) begin
          pass_d     = seq.i_seq_ex_passes;
          ex_first_d = 1'b0;
        end
        if (last) begin
          if (pass_q != 2'd0) pass_d  = pass_q - 2'd1;
          else                state_d = seq.i_seq_redirect ? JUMP : ADDR;
        end
      end
      JUMP: if (last) state_d = ADDR;
      default: begin
        state_d = ADDR;
        ctr_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_seq_gck or negedge i_seq_rst_n) begin
    if (!i_seq_rst_n) begin
      state_q    <= IDLE;
      ctr_q      <= 2'd0;
      pass_q     <= 2'd0;
      ex_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      pass_q     <= pass_d;
      ex_first_q <= ex_first_d;
    end
  end

  assign seq.o_seq_state      = state_q;
  assign seq.o_seq_ctr        = ctr_q;
  assign seq.o_seq_last_cycle = last;
  assign seq.o_seq_pc_en      = (state_q == ADDR) || (state_q == JUMP);
  assign seq.o_seq_pc_ld      = (state_q == JUMP);
  assign seq.o_seq_mem_req    = (state_q == ADDR) || (state_q == DATA);
  assign seq.o_seq_ir_en      = (state_q == DATA) && seq.i_seq_mem_rdy;
  assign seq.o_seq_ex_en      = (state_q == EXEC) && !seq.i_seq_ex_wait;

endmodule

// File: tb/tb_idli_seq_m.sv
// Scenario bench for idli_seq_m: expected per-cycle observations are queued as stimulus is applied
// and popped at the falling edge, when the combinational outputs have settled.
module tb_idli_seq_m;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_JUMP = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] ctr;
    logic       last;
    logic       pc_en;
    logic       pc_ld;
    logic       mem_req;
    logic       ir_en;
    logic       ex_en;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  obs_t exp_q[$];

  idli_seq_m_if sif ();

  idli_seq_m dut (
    .i_seq_gck   (clk),
    .i_seq_rst_n (rst_n),
    .seq         (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [2:0] st, input logic [1:0] c, input logic last,
                              input logic ir, input logic ex);
    obs_t e;
    e.st      = st;
    e.ctr     = c;
    e.last    = last;
    e.pc_en   = (st == S_ADDR) || (st == S_JUMP);
    e.pc_ld   = (st == S_JUMP);
    e.mem_req = (st == S_ADDR) || (st == S_DATA);
    e.ir_en   = ir;
    e.ex_en   = ex;
    return e;
  endfunction

  // Uninterrupted IDLE/ADDR/DATA prologue for cycles 0..8 after reset release.
  function automatic obs_t front(input int k);
    int c;
    c = (k - 1) % 4;
    if (k == 0)     return mk(S_IDLE, 2'd0, 1'b0, 1'b0, 1'b0);
    else if (k < 5) return mk(S_ADDR, c[1:0], c == 3, 1'b0, 1'b0);
    else            return mk(S_DATA, c[1:0], c == 3, 1'b1, 1'b0);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st      = sif.o_seq_state;
    o.ctr     = sif.o_seq_ctr;
    o.last    = sif.o_seq_last_cycle;
    o.pc_en   = sif.o_seq_pc_en;
    o.pc_ld   = sif.o_seq_pc_ld;
    o.mem_req = sif.o_seq_mem_req;
    o.ir_en   = sif.o_seq_ir_en;
    o.ex_en   = sif.o_seq_ex_en;
    return o;
  endfunction

  task automatic drive(input logic rdy, input logic [1:0] p, input logic w, input logic r);
    sif.i_seq_mem_rdy   = rdy;
    sif.i_seq_ex_passes = p;
    sif.i_seq_ex_wait   = w;
    sif.i_seq_redirect  = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, got;
    drive(1'b1, 2'd3, 1'b0, 1'b1);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(S_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_basic();
    obs_t e, got;
    int m;
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      drive(1'b1, 2'd0, 1'b0, 1'b0);
      m = (k - 1) % 12;
      if (k == 0)          e = mk(S_IDLE, 2'd0, 1'b0, 1'b0, 1'b0);
      else if (m < 4)      e = mk(S_ADDR, m[1:0], m == 3, 1'b0, 1'b0);
      else if (m < 8)      e = mk(S_DATA, m[1:0], m == 7, 1'b1, 1'b0);
      else                 e = mk(S_EXEC, m[1:0], m == 11, 1'b0, 1'b1);
      exp_q.push_back(e);
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL basic k=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_stall();
    obs_t e, got;
    logic stall;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      stall = (k >= 7) && (k <= 9);
      drive(!stall, 2'd0, 1'b0, 1'b0);
      if (k <= 6)       e = front(k);
      else if (stall)   e = mk(S_DATA, 2'd2, 1'b0, 1'b0, 1'b0);
      else if (k == 10) e = mk(S_DATA, 2'd2, 1'b0, 1'b1, 1'b0);
      else if (k == 11) e = mk(S_DATA, 2'd3, 1'b1, 1'b1, 1'b0);
      else if (k <= 15) e = mk(S_EXEC, 2'(k - 12), k == 15, 1'b0, 1'b1);
      else              e = mk(S_ADDR, 2'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL mem_stall k=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_pass();
    obs_t e, got;
    logic [1:0] p;
    int c;
    do_reset();
    for (int k = 0; k <= 21; k++) begin
      p = (k == 9) ? 2'd2 : ((k >= 10) ? 2'd3 : 2'd0);
      drive(1'b1, p, 1'b0, k == 16);
      c = (k - 9) % 4;
      if (k <= 8)       e = front(k);
      else if (k <= 20) e = mk(S_EXEC, c[1:0], c == 3, 1'b0, 1'b1);
      else              e = mk(S_ADDR, 2'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL multi_pass k=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    obs_t e, got;
    do_reset();
    for (int k = 0; k <= 18; k++) begin
      drive(1'b1, 2'd0, 1'b0, (k == 3) || (k == 10) || (k == 12) || (k == 18));
      if (k <= 8)       e = front(k);
      else if (k <= 12) e = mk(S_EXEC, 2'(k - 9), k == 12, 1'b0, 1'b1);
      else if (k <= 16) e = mk(S_JUMP, 2'(k - 13), k == 16, 1'b0, 1'b0);
      else              e = mk(S_ADDR, 2'(k - 17), 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL redirect k=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ex_stall();
    obs_t e, got;
    logic w;
    do_reset();
    for (int k = 0; k <= 19; k++) begin
      w = (k == 12) || (k == 13);
      drive(1'b1, 2'd1, w, w);
      if (k <= 8)       e = front(k);
      else if (k <= 11) e = mk(S_EXEC, 2'(k - 9), 1'b0, 1'b0, 1'b1);
      else if (w)       e = mk(S_EXEC, 2'd3, 1'b0, 1'b0, 1'b0);
      else if (k == 14) e = mk(S_EXEC, 2'd3, 1'b1, 1'b0, 1'b1);
      else if (k <= 18) e = mk(S_EXEC, 2'(k - 15), k == 18, 1'b0, 1'b1);
      else              e = mk(S_ADDR, 2'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL ex_stall k=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, got;
    do_reset();
    for (int k = 0; k <= 7; k++) begin
      drive(1'b1, 2'd0, 1'b0, 1'b0);
      exp_q.push_back(front(k));
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, got, e);
      end
      if (k != 7) begin
        @(posedge clk); #1;
      end
    end
    // Assert reset between edges while DATA ctr=2 with rdy high.
    #1 rst_n = 1'b0;
    exp_q.push_back(mk(S_IDLE, 2'd0, 1'b0, 1'b0, 1'b0));
    #1;
    got = sample();
    e   = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", got, e);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      exp_q.push_back(front(k));
      @(negedge clk);
      got = sample();
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL reset_mid_restart k=%0d got=%h exp=%h", k, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_mem_stall();
    test_multi_pass();
    test_redirect();
    test_ex_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
